// File: rtl/game_geometry_pkg.sv
// Shared breakout geometry: tile grid, derived pixel limits and the rally state encoding.
// The renderer imports this same package so both sides agree on where walls and paddle sit.
package game_geometry_pkg;

  // Tile grid
  localparam int unsigned TILE_PX         = 8;
  localparam int unsigned SCREEN_W        = 800;
  localparam int unsigned SCREEN_H        = 600;
  localparam int unsigned WALL_L_TILE_COL = 0;
  localparam int unsigned WALL_R_TILE_COL = SCREEN_W / TILE_PX - 1;
  localparam int unsigned CEIL_TILE_ROW   = 9;
  localparam int unsigned PADDLE_TILE_ROW = 73;

  // Pixel limits derived from the tile grid
  localparam int unsigned X_MIN        = (WALL_L_TILE_COL + 1) * TILE_PX;  // 8
  localparam int unsigned X_END        = WALL_R_TILE_COL * TILE_PX;        // 792, first wall pixel
  localparam int unsigned BALL_Y_MIN   = (CEIL_TILE_ROW + 1) * TILE_PX;    // 80
  localparam int unsigned PADDLE_Y_TOP = PADDLE_TILE_ROW * TILE_PX;        // 584
  localparam int unsigned LOSS_Y       = SCREEN_H;                         // 600

  // Rally sequencing; the numeric values are visible on the STATE output.
  typedef enum logic [1:0] {
    StServe = 2'd0,
    StPlay  = 2'd1,
    StLost  = 2'd2
  } phys_state_e;

  // Rightmost legal ball left edge for a given ball size (784 for an 8 px ball).
  function automatic int unsigned ball_x_max(input int unsigned ball_size);
    return X_END - ball_size;
  endfunction

  // Rightmost legal paddle left edge for a given paddle length (732 for 60 px).
  function automatic int unsigned paddle_x_max(input int unsigned paddle_len);
    return X_END - paddle_len;
  endfunction

  // Ball top edge when resting on the paddle (576 for an 8 px ball).
  function automatic int unsigned rest_y(input int unsigned ball_size);
    return PADDLE_Y_TOP - ball_size;
  endfunction

endpackage

// File: rtl/game_physics_if.sv
// Frame/button inputs and draw-position outputs between the board/renderer and game_physics.
interface game_physics_if;

  logic       FRAME_DONE;
  logic       BTN_LEFT;
  logic       BTN_RIGHT;
  logic       BTN_SERVE;
  logic [9:0] PADDLE_X_PIXEL;
  logic [9:0] BALL_X_PIXEL;
  logic [9:0] BALL_Y_PIXEL;
  logic [1:0] STATE;
  logic       PADDLE_HIT;
  logic       BALL_LOST;

  // Renderer / board side
  modport master (
    output FRAME_DONE, BTN_LEFT, BTN_RIGHT, BTN_SERVE,
    input  PADDLE_X_PIXEL, BALL_X_PIXEL, BALL_Y_PIXEL, STATE, PADDLE_HIT, BALL_LOST
  );

  // Physics engine side
  modport slave (
    input  FRAME_DONE, BTN_LEFT, BTN_RIGHT, BTN_SERVE,
    output PADDLE_X_PIXEL, BALL_X_PIXEL, BALL_Y_PIXEL, STATE, PADDLE_HIT, BALL_LOST
  );

endinterface

// File: rtl/button_sync.sv
// Two-flop synchronizer for a bundle of independent asynchronous button levels.
module button_sync #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] btn_async,
  output logic [WIDTH-1:0] btn_sync
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // First flop may go metastable; second flop gives it a full cycle to settle.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= btn_async;
      sync_q <= meta_q;
    end
  end

  assign btn_sync = sync_q;

endmodule

// File: rtl/game_physics.sv
// Breakout game-state engine: once per FRAME_DONE tick it moves the paddle, moves and bounces
// the ball, and sequences serve -> play -> lost. All outputs are registered.
module game_physics
  import game_geometry_pkg::*;
#(
  parameter int unsigned PADDLE_LENGTH_PIXEL = 60,
  parameter int unsigned BALL_SIZE_PIXEL     = 8,
  parameter int unsigned BALL_SPEED          = 2,  // 1..7
  parameter int unsigned PADDLE_SPEED        = 4,  // 1..8
  parameter int unsigned LOST_FRAMES         = 60  // 1..255
) (
  input logic          CLK,
  input logic          RESET,
  game_physics_if.slave bus
);

  // 11-bit versions so x + width comparisons never wrap.
  localparam logic [10:0] XMIN_W        = 11'(X_MIN);
  localparam logic [10:0] BALL_XMAX_W   = 11'(ball_x_max(BALL_SIZE_PIXEL));
  localparam logic [10:0] PADDLE_XMAX_W = 11'(paddle_x_max(PADDLE_LENGTH_PIXEL));
  localparam logic [10:0] YMIN_W        = 11'(BALL_Y_MIN);
  localparam logic [10:0] REST_Y_W      = 11'(rest_y(BALL_SIZE_PIXEL));
  localparam logic [10:0] LOSS_Y_W      = 11'(LOSS_Y);
  localparam logic [10:0] BSPD_W        = 11'(BALL_SPEED);
  localparam logic [10:0] PSPD_W        = 11'(PADDLE_SPEED);
  localparam logic [10:0] BSIZE_W       = 11'(BALL_SIZE_PIXEL);
  localparam logic [10:0] PLEN_W        = 11'(PADDLE_LENGTH_PIXEL);

  localparam logic [9:0]  SERVE_OFS      = 10'((PADDLE_LENGTH_PIXEL - BALL_SIZE_PIXEL) / 2);
  localparam logic [9:0]  PADDLE_X_RESET = 10'((SCREEN_W - PADDLE_LENGTH_PIXEL) / 2);
  localparam logic [7:0]  LOST_LOAD      = 8'(LOST_FRAMES);

  localparam int unsigned BtnLeft  = 0;
  localparam int unsigned BtnRight = 1;
  localparam int unsigned BtnServe = 2;

  logic [2:0] btn_raw;
  logic [2:0] btn_sync;
  logic       btn_left;
  logic       btn_right;
  logic       btn_serve;

  phys_state_e state_q;
  logic [9:0]  paddle_x_q;
  logic [9:0]  ball_x_q;
  logic [9:0]  ball_y_q;
  logic        dx_pos_q;   // 1: moving right
  logic        dy_down_q;  // 1: moving down
  logic        hit_q;
  logic        lost_q;
  logic [7:0]  frame_cnt_q;

  logic [9:0]  paddle_next;
  logic [9:0]  serve_x;
  logic [10:0] paddle_ext;
  logic [10:0] ball_x_ext;
  logic [10:0] ball_y_ext;
  logic [10:0] nx;
  logic [10:0] ny;
  logic [9:0]  step_x;
  logic [9:0]  step_y;
  logic        step_dx;
  logic        step_dy;
  logic        step_hit;
  logic        step_lost;

  assign btn_raw = {bus.BTN_SERVE, bus.BTN_RIGHT, bus.BTN_LEFT};

  button_sync #(
    .WIDTH(3)
  ) u_button_sync (
    .CLK      (CLK),
    .RESET    (RESET),
    .btn_async(btn_raw),
    .btn_sync (btn_sync)
  );

  assign btn_left  = btn_sync[BtnLeft];
  assign btn_right = btn_sync[BtnRight];
  assign btn_serve = btn_sync[BtnServe];

  assign paddle_ext = {1'b0, paddle_x_q};
  assign ball_x_ext = {1'b0, ball_x_q};
  assign ball_y_ext = {1'b0, ball_y_q};

  // Paddle position for this tick; opposing buttons cancel.
  always_comb begin
    paddle_next = paddle_x_q;
    if (btn_left && !btn_right) begin
      if (paddle_ext < XMIN_W + PSPD_W) paddle_next = XMIN_W[9:0];
      else                              paddle_next = paddle_x_q - PSPD_W[9:0];
    end else if (btn_right && !btn_left) begin
      if (paddle_ext + PSPD_W > PADDLE_XMAX_W) paddle_next = PADDLE_XMAX_W[9:0];
      else                                     paddle_next = paddle_x_q + PSPD_W[9:0];
    end
  end

  // Ball centred on the paddle, using the paddle position after this tick's move.
  assign serve_x = paddle_next + SERVE_OFS;

  // One play step; x and y resolve independently so corner bounces flip both axes.
  always_comb begin
    nx        = dx_pos_q  ? ball_x_ext + BSPD_W : ball_x_ext - BSPD_W;
    ny        = dy_down_q ? ball_y_ext + BSPD_W : ball_y_ext - BSPD_W;
    step_x    = nx[9:0];
    step_dx   = dx_pos_q;
    step_y    = ny[9:0];
    step_dy   = dy_down_q;
    step_hit  = 1'b0;
    step_lost = 1'b0;

    if (!dx_pos_q && nx < XMIN_W) begin
      step_x  = XMIN_W[9:0];
      step_dx = 1'b1;
    end else if (dx_pos_q && nx > BALL_XMAX_W) begin
      step_x  = BALL_XMAX_W[9:0];
      step_dx = 1'b0;
    end

    // Paddle overlap is judged against the pre-tick paddle position.
    if (!dy_down_q && ny < YMIN_W) begin
      step_y  = YMIN_W[9:0];
      step_dy = 1'b1;
    end else if (dy_down_q && ball_y_ext <= REST_Y_W && ny >= REST_Y_W &&
                 nx + BSIZE_W > paddle_ext && nx < paddle_ext + PLEN_W) begin
      step_y   = REST_Y_W[9:0];
      step_dy  = 1'b0;
      step_hit = 1'b1;
    end else if (dy_down_q && ny >= LOSS_Y_W) begin
      step_lost = 1'b1;
    end
  end

  // Rally FSM and all position state; everything advances only on the frame tick.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= StServe;
      paddle_x_q  <= PADDLE_X_RESET;
      ball_x_q    <= PADDLE_X_RESET + SERVE_OFS;
      ball_y_q    <= REST_Y_W[9:0];
      dx_pos_q    <= 1'b1;
      dy_down_q   <= 1'b0;
      hit_q       <= 1'b0;
      lost_q      <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      hit_q  <= 1'b0;
      lost_q <= 1'b0;
      if (bus.FRAME_DONE) begin
        paddle_x_q <= paddle_next;
        unique case (state_q)
          StServe: begin
            ball_x_q <= serve_x;
            ball_y_q <= REST_Y_W[9:0];
            if (btn_serve) begin
              state_q   <= StPlay;
              dx_pos_q  <= 1'b1;
              dy_down_q <= 1'b0;
            end
          end
          StPlay: begin
            ball_x_q  <= step_x;
            ball_y_q  <= step_y;
            dx_pos_q  <= step_dx;
            dy_down_q <= step_dy;
            hit_q     <= step_hit;
            if (step_lost) begin
              state_q     <= StLost;
              lost_q      <= 1'b1;
              frame_cnt_q <= LOST_LOAD;
            end
          end
          StLost: begin
            // <= 1 rather than == 1 so a stray zero count cannot wedge the FSM.
            if (frame_cnt_q <= 8'd1) begin
              state_q     <= StServe;
              ball_x_q    <= serve_x;
              ball_y_q    <= REST_Y_W[9:0];
              frame_cnt_q <= 8'd0;
            end else begin
              frame_cnt_q <= frame_cnt_q - 8'd1;
            end
          end
          default: state_q <= StServe;
        endcase
      end
    end
  end

  assign bus.PADDLE_X_PIXEL = paddle_x_q;
  assign bus.BALL_X_PIXEL   = ball_x_q;
  assign bus.BALL_Y_PIXEL   = ball_y_q;
  assign bus.STATE          = state_q;
  assign bus.PADDLE_HIT     = hit_q;
  assign bus.BALL_LOST      = lost_q;

endmodule

// File: tb/tb_game_physics.sv
// Scoreboard bench for game_physics: directed rallies with hand-computed positions.
module tb_game_physics;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;

  game_physics_if bus();

  game_physics #(
    .PADDLE_LENGTH_PIXEL(60),
    .BALL_SIZE_PIXEL    (8),
    .BALL_SPEED         (2),
    .PADDLE_SPEED       (4),
    .LOST_FRAMES        (60)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int    at_tick;
    bit    now;
    int    px;
    int    bx;
    int    by;
    int    st;
    int    hit;
    int    lost;
    string name;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp     = 0;
  int   n_fail    = 0;
  int   stim_tick = 0;
  int   mon_tick  = 0;
  logic fd_prev   = 1'b0;
  exp_t mon_e;

  always @(posedge CLK) fd_prev <= bus.FRAME_DONE;

  task automatic cmp_field(input string name, input string field, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s %s: got %0d, required %0d", name, field, act, req);
    end
  endtask

  // Monitor: after each tick (or on demand) pop the expectation and compare all outputs.
  initial begin
    forever begin
      @(negedge CLK);
      if (fd_prev) mon_tick++;
      while (sb_q.size() > 0 &&
             (sb_q[0].now || (fd_prev && sb_q[0].at_tick == mon_tick) ||
              sb_q[0].at_tick < mon_tick)) begin
        mon_e = sb_q.pop_front();
        if (!mon_e.now && mon_e.at_tick < mon_tick) begin
          n_cmp++;
          n_fail++;
          $display("FAIL %s missed: tick %0d passed, now at %0d", mon_e.name, mon_e.at_tick,
                   mon_tick);
        end else begin
          cmp_field(mon_e.name, "paddle_x", int'(bus.PADDLE_X_PIXEL), mon_e.px);
          cmp_field(mon_e.name, "ball_x",   int'(bus.BALL_X_PIXEL),   mon_e.bx);
          cmp_field(mon_e.name, "ball_y",   int'(bus.BALL_Y_PIXEL),   mon_e.by);
          cmp_field(mon_e.name, "state",    int'(bus.STATE),          mon_e.st);
          cmp_field(mon_e.name, "hit",      int'(bus.PADDLE_HIT),     mon_e.hit);
          cmp_field(mon_e.name, "lost",     int'(bus.BALL_LOST),      mon_e.lost);
        end
      end
    end
  end

  // Expect outputs after the rel-th tick of the burst about to be issued.
  task automatic chk(input int rel, input int px, input int bx, input int by, input int st,
                     input int hit, input int lost, input string name);
    exp_t e;
    e.at_tick = stim_tick + rel;
    e.now     = 1'b0;
    e.px      = px;
    e.bx      = bx;
    e.by      = by;
    e.st      = st;
    e.hit     = hit;
    e.lost    = lost;
    e.name    = name;
    sb_q.push_back(e);
  endtask

  task automatic chk_now(input string name);
    exp_t e;
    e.at_tick = 0;
    e.now     = 1'b1;
    e.px      = 370;
    e.bx      = 396;
    e.by      = 576;
    e.st      = 0;
    e.hit     = 0;
    e.lost    = 0;
    e.name    = name;
    sb_q.push_back(e);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      bus.FRAME_DONE = 1'b1;
      @(posedge CLK);
      #1;
      stim_tick++;
    end
    bus.FRAME_DONE = 1'b0;
  endtask

  // Change buttons, then idle long enough for the synchronizer to pass them through.
  task automatic set_btn(input logic l, input logic r, input logic s);
    bus.BTN_LEFT  = l;
    bus.BTN_RIGHT = r;
    bus.BTN_SERVE = s;
    repeat (3) @(posedge CLK);
    #1;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb_q.size() > 0 && k < 50) begin
      @(negedge CLK);
      k++;
    end
    if (sb_q.size() > 0) begin
      $display("FAIL drain: %0d expectations never compared, required 0", sb_q.size());
      n_cmp  += sb_q.size();
      n_fail += sb_q.size();
      sb_q.delete();
    end
    @(posedge CLK);
    #1;
  endtask

  // Raise reset between clock edges so the check sees whether it acts asynchronously.
  task automatic pulse_reset(input string name);
    drain();
    #2;
    RESET = 1'b1;
    chk_now(name);
    drain();
    RESET = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    bus.FRAME_DONE = 1'b0;
    bus.BTN_LEFT   = 1'b0;
    bus.BTN_RIGHT  = 1'b0;
    bus.BTN_SERVE  = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk_now("reset_state");
    drain();
    RESET = 1'b0;
    @(posedge CLK);
    #1;

    // Paddle sweeps with the ball riding on it
    set_btn(1'b0, 1'b1, 1'b0);
    chk(1,  374, 400, 576, 0, 0, 0, "right_t1");
    chk(10, 410, 436, 576, 0, 0, 0, "right_t10");
    chk(90, 730, 756, 576, 0, 0, 0, "right_t90");
    chk(91, 732, 758, 576, 0, 0, 0, "right_clamp");
    chk(95, 732, 758, 576, 0, 0, 0, "right_hold_max");
    ticks(95);
    set_btn(1'b1, 1'b0, 1'b0);
    chk(1, 728, 754, 576, 0, 0, 0, "left_from_732");
    ticks(1);
    set_btn(1'b0, 1'b1, 1'b0);
    chk(1, 732, 758, 576, 0, 0, 0, "right_728_to_732");
    chk(2, 732, 758, 576, 0, 0, 0, "right_stays_732");
    ticks(2);
    set_btn(1'b1, 1'b1, 1'b0);
    chk(2, 732, 758, 576, 0, 0, 0, "both_hold");
    ticks(2);
    set_btn(1'b1, 1'b0, 1'b0);
    chk(180, 12, 38, 576, 0, 0, 0, "left_t180");
    chk(181, 8,  34, 576, 0, 0, 0, "left_clamp");
    chk(185, 8,  34, 576, 0, 0, 0, "left_hold_min");
    ticks(185);
    set_btn(1'b0, 1'b0, 1'b0);
    pulse_reset("reset_after_paddle");

    // Rally 1: serve, right wall, ceiling, paddle hit, left wall, ceiling, right wall, loss
    set_btn(1'b0, 1'b0, 1'b1);
    chk(1, 370, 396, 576, 1, 0, 0, "serve_tick");
    ticks(1);
    set_btn(1'b0, 1'b0, 1'b0);
    chk(1,   370, 398, 574, 1, 0, 0, "play_first_step");
    chk(194, 370, 784, 188, 1, 0, 0, "reach_right_wall");
    chk(195, 370, 784, 186, 1, 0, 0, "right_wall_clamp");
    chk(196, 370, 782, 184, 1, 0, 0, "right_wall_rebound");
    ticks(200);
    set_btn(1'b1, 1'b0, 1'b0);
    chk(48, 178, 678, 80, 1, 0, 0, "reach_ceiling");
    chk(49, 174, 676, 80, 1, 0, 0, "ceiling_clamp");
    chk(50, 170, 674, 82, 1, 0, 0, "ceiling_rebound");
    ticks(55);
    set_btn(1'b0, 1'b0, 1'b0);
    chk(242, 150, 180, 576, 1, 1, 0, "paddle_hit");
    chk(243, 150, 178, 574, 1, 0, 0, "after_hit");
    chk(328, 150, 8,   404, 1, 0, 0, "reach_left_wall");
    chk(329, 150, 8,   402, 1, 0, 0, "left_wall_clamp");
    chk(330, 150, 10,  400, 1, 0, 0, "left_wall_rebound");
    chk(491, 150, 332, 80,  1, 0, 0, "ceiling2_clamp");
    chk(492, 150, 334, 82,  1, 0, 0, "ceiling2_rebound");
    chk(717, 150, 784, 532, 1, 0, 0, "reach_right_wall2");
    chk(718, 150, 784, 534, 1, 0, 0, "right_wall2_clamp");
    chk(719, 150, 782, 536, 1, 0, 0, "right_wall2_rebound");
    chk(750, 150, 720, 598, 1, 0, 0, "pre_loss");
    chk(751, 150, 718, 600, 2, 0, 1, "ball_lost");
    ticks(751);

    // LOST: serve ignored, ball frozen, back to SERVE after 60 ticks
    set_btn(1'b0, 1'b0, 1'b1);
    chk(1,  150, 718, 600, 2, 0, 0, "lost_pulse_once");
    chk(10, 150, 718, 600, 2, 0, 0, "lost_ignores_serve");
    ticks(10);
    set_btn(1'b0, 1'b0, 1'b0);
    chk(49, 150, 718, 600, 2, 0, 0, "lost_last_frame");
    chk(50, 150, 176, 576, 0, 0, 0, "lost_to_serve");
    chk(51, 150, 176, 576, 0, 0, 0, "serve_idle");
    ticks(51);

    // Rally 2 ends in LOST, then reset lands mid-countdown
    set_btn(1'b0, 1'b0, 1'b1);
    chk(1, 150, 176, 576, 1, 0, 0, "serve2");
    ticks(1);
    set_btn(1'b0, 1'b0, 1'b0);
    chk(249, 150, 674, 80,  1, 0, 0, "ceiling3_clamp");
    chk(509, 150, 376, 600, 2, 0, 1, "ball_lost2");
    ticks(509);
    chk(30, 150, 376, 600, 2, 0, 0, "lost2_frozen");
    ticks(30);
    pulse_reset("reset_mid_lost");

    chk(1, 370, 396, 576, 0, 0, 0, "post_reset_idle");
    ticks(1);
    set_btn(1'b0, 1'b0, 1'b1);
    chk(1, 370, 396, 576, 1, 0, 0, "serve3");
    ticks(1);
    set_btn(1'b0, 1'b0, 1'b0);
    chk(1, 370, 398, 574, 1, 0, 0, "serve3_step1");
    chk(2, 370, 400, 572, 1, 0, 0, "serve3_step2");
    ticks(2);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/game_physics.md
# game_physics

Game-state engine for the breakout core. It consumes the renderer's once-per-frame FRAME_DONE strobe and player buttons, and produces the paddle and ball pixel positions that the renderer draws. Positions advance exactly once per frame: paddle motion, ball motion, wall/ceiling/paddle bounces and ball loss. A three-state serve/play/lost machine sequences each rally.

## Interface
Parameters:
- PADDLE_LENGTH_PIXEL, 60: paddle width in pixels; must match the renderer.
- BALL_SIZE_PIXEL, 8: ball edge length in pixels.
- BALL_SPEED, 2: pixels per frame on each axis; legal range 1..7.
- PADDLE_SPEED, 4: pixels per frame; legal range 1..8.
- LOST_FRAMES, 60: frames spent in LOST before returning to SERVE; range 1..255.

Ports:
- CLK  in  1  system clock, same domain as the renderer.
- RESET  in  1  asynchronous, active-high reset.
- FRAME_DONE  in  1  one-cycle frame tick from the renderer.
- BTN_LEFT, BTN_RIGHT, BTN_SERVE  in  1 each  raw asynchronous button levels.
- PADDLE_X_PIXEL  out  10  paddle left edge.
- BALL_X_PIXEL, BALL_Y_PIXEL  out  10 each  ball top-left corner.
- STATE  out  2  0 SERVE, 1 PLAY, 2 LOST.
- PADDLE_HIT  out  1  one-cycle pulse when the ball bounces off the paddle.
- BALL_LOST  out  1  one-cycle pulse on entry to LOST.

## Operation
- Geometry constants:
  - Interior x range is 8..791: left wall at 0..7, right wall at 792..799.
  - Interior y starts at 80: ceiling at 72..79.
  - Paddle row is y 584..591. Ball resting y is PADDLE_Y_TOP - BALL_SIZE = 576.
  - Limits: X_MIN=8, BALL_X_MAX=784, PADDLE_X_MAX=732, BALL_Y_MIN=80, LOSS_Y=600.
- Buttons pass through a 2-flop synchronizer. Only synchronized levels are used.
- The "tick" is the cycle in which FRAME_DONE=1. All state updates happen on the tick. Every register holds between ticks.
- Paddle, every state:
  - Left only: x = max(X_MIN, x - PADDLE_SPEED).
  - Right only: x = min(PADDLE_X_MAX, x + PADDLE_SPEED).
  - Both buttons or neither: hold.
- SERVE:
  - The ball rides on the paddle: ball_x = new paddle_x + (PADDLE_LENGTH - BALL_SIZE)/2, ball_y = 576.
  - BTN_SERVE high on a tick → PLAY with dx=+, dy=−. The ball stays at the serve position on that tick.
- PLAY: compute nx = x ± BALL_SPEED, ny = y ± BALL_SPEED.
  - Moving left and nx < X_MIN: x=X_MIN, dx becomes +.
  - Moving right and nx > BALL_X_MAX: x=BALL_X_MAX, dx becomes −.
  - Moving up and ny < BALL_Y_MIN: y=BALL_Y_MIN, dy becomes +.
  - Paddle hit requires all of: moving down, y ≤ 576 and ny ≥ 576, nx+BALL_SIZE > paddle_x, and nx < paddle_x + PADDLE_LENGTH. Overlap uses the pre-tick paddle_x. On a hit: y=576, dy becomes −, PADDLE_HIT pulses.
  - If the ball misses the paddle it keeps falling. When ny ≥ LOSS_Y: y=ny, → LOST, BALL_LOST pulses.
  - Simultaneous wall and ceiling, or wall and paddle, events resolve independently per axis. Corner bounces flip both axes.
- LOST:
  - Ball frozen. The frame counter loads LOST_FRAMES on entry and decrements each tick.
  - On the tick where the counter equals 1: → SERVE, and the ball snaps to the serve position on that same tick.
  - Buttons other than left/right are ignored.
- Arithmetic:
  - 10-bit unsigned throughout.
  - Legal parameter ranges guarantee no underflow, because x ≥ 8 > speed.
  - Comparisons use 11-bit sums so x + width never wraps.

## Timing
- Reset values:
  - PADDLE_X_PIXEL=370, BALL_X_PIXEL=396, BALL_Y_PIXEL=576.
  - STATE=SERVE, dx=+, dy=−.
  - PADDLE_HIT=0, BALL_LOST=0, counter=0, synchronizer flops=0.
- Latency:
  - Position outputs are registered and change on the clock edge after the tick cycle, one cycle after FRAME_DONE.
  - PADDLE_HIT and BALL_LOST are high for exactly that one cycle.
- Button latency: 2 cycles of synchronization. A press must be stable ≥ 3 cycles before a tick to be seen.
- Back-to-back FRAME_DONE pulses produce one update per high cycle. No tick coalescing.
- RESET asserted at any time, including mid-LOST: all registers go to reset values asynchronously. Release is synchronized in the upstream reset tree.

## Structure
- The shared package `game_geometry_pkg` holds:
  - tile and pixel geometry (ceiling, wall, paddle-row tiles; X_MIN, BALL_X_MAX, BALL_Y_MIN, LOSS_Y, SCREEN_W/H);
  - the state encoding constants.
- The renderer is switched over to the same package so geometry has one source.
- One sub-module, `button_sync`: parameterized-width 2-flop synchronizer, instantiated once with width 3.

## Test plan
- Reset, then 10 ticks with BTN_RIGHT held, PADDLE_SPEED=4 → PADDLE_X_PIXEL=410, ball x=436 tracking it, STATE=0.
- Paddle at 728, BTN_RIGHT held for 2 ticks → x=732, then stays 732. Mirror test: paddle clamps at 8 on the left.
- Serve from reset, BALL_SPEED=2 → after 1 tick STATE=1 and ball at (396,576); after 2 ticks (398,574).
- Ball at x=783 moving right → next tick x=784, then x=782. Ball at y=81 moving up → y=80, then 82.
- Ball descending to (400,576) with paddle at 370 → PADDLE_HIT pulse, y=576, next tick y=574.
- Paddle at 8 and ball falling at x=600 → BALL_LOST pulses once y reaches ≥600. After LOST_FRAMES ticks STATE=0 and the ball sits on the paddle. RESET asserted mid-LOST restores all reset values immediately.
